// File: rtl/formula_sum_isqrt_pkg.sv
// Shared types and helpers for the isqrt-sum formula blocks.
// Latency: none (package only).
// Backpressure: none (package only).
// Contents: state_t FSM encoding, calc_rounds() issue-round count.
package formula_sum_isqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Number of issue rounds needed to push n_args operands through n_units units.
  function automatic int calc_rounds(input int n_args, input int n_units);
    return (n_args + n_units - 1) / n_units;
  endfunction

endpackage

// File: rtl/isqrt_masked_sum.sv
// Sums the isqrt result slices of all units that are both valid and pending.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the sum is consumed.
// Ports: y (N_UNITS packed W/2-bit results), vld/pending (per-unit masks),
//        sum (W-bit zero-extended total, wraps modulo 2^W).
module isqrt_masked_sum #(
  parameter int W       = 32,
  parameter int N_UNITS = 2
) (
  input  logic [N_UNITS*(W/2)-1:0] y,
  input  logic [N_UNITS-1:0]       vld,
  input  logic [N_UNITS-1:0]       pending,
  output logic [W-1:0]             sum
);

  localparam int HW = W / 2;

  always_comb begin
    sum = '0;
    for (int u = 0; u < N_UNITS; u++) begin
      if (vld[u] && pending[u]) begin
        sum = sum + {{(W - HW){1'b0}}, y[u*HW +: HW]};
      end
    end
  end

endmodule

// File: rtl/formula_sum_isqrt_n_fsm.sv
// Computes sum of isqrt(arg[i]) over N_ARGS operands using N_UNITS external isqrt units.
// Latency: ROUNDS*(L+1)+1 cycles from handshake to res_vld for a fixed unit latency L.
// Backpressure: arg_rdy is high only in IDLE; callers hold arg_vld until accepted.
// Ports: clk/rst (sync, active-high); arg_vld/arg_rdy/args operand handshake;
//        res_vld/res one-cycle result strobe (res holds until next accept);
//        isqrt_x_vld/isqrt_x requests to units; isqrt_y_vld/isqrt_y unit results.
module formula_sum_isqrt_n_fsm
  import formula_sum_isqrt_pkg::*;
#(
  parameter int W       = 32,
  parameter int N_ARGS  = 3,
  parameter int N_UNITS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arg_vld,
  output logic                     arg_rdy,
  input  logic [N_ARGS*W-1:0]      args,
  output logic                     res_vld,
  output logic [W-1:0]             res,
  output logic [N_UNITS-1:0]       isqrt_x_vld,
  output logic [N_UNITS*W-1:0]     isqrt_x,
  input  logic [N_UNITS-1:0]       isqrt_y_vld,
  input  logic [N_UNITS*W/2-1:0]   isqrt_y
);

  localparam int ROUNDS = calc_rounds(N_ARGS, N_UNITS);
  localparam int RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  state_t              state;
  state_t              state_nxt;
  logic [RW-1:0]       round;
  logic [N_UNITS-1:0]  pending;
  logic [N_UNITS-1:0]  pending_left;
  logic [N_UNITS-1:0]  issue_mask;
  logic [W-1:0]        acc;
  logic [W-1:0]        arrive_sum;
  logic [N_ARGS*W-1:0] args_q;
  logic                accept;
  logic                all_clear;
  logic                last_round;

  assign accept       = (state == ST_IDLE) && arg_vld;
  // Results arriving this cycle retire their pending bit immediately, so the
  // round can close in the same cycle as its last arrival.
  assign pending_left = pending & ~isqrt_y_vld;
  assign all_clear    = (pending_left == '0);
  assign last_round   = (round == RW'(ROUNDS - 1));
  assign res          = acc;

  isqrt_masked_sum #(
    .W       (W),
    .N_UNITS (N_UNITS)
  ) u_masked_sum (
    .y       (isqrt_y),
    .vld     (isqrt_y_vld),
    .pending (pending),
    .sum     (arrive_sum)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (all_clear) state_nxt = last_round ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: unit requests exist only in ISSUE; operands are zero elsewhere.
  always_comb begin
    int k;
    k           = 0;
    arg_rdy     = (state == ST_IDLE);
    res_vld     = (state == ST_DONE);
    issue_mask  = '0;
    isqrt_x     = '0;
    if (state == ST_ISSUE) begin
      for (int u = 0; u < N_UNITS; u++) begin
        k = int'(round) * N_UNITS + u;
        if (k < N_ARGS) begin
          issue_mask[u]      = 1'b1;
          isqrt_x[u*W +: W]  = args_q[k*W +: W];
        end
      end
    end
    isqrt_x_vld = issue_mask;
  end

  // Datapath: operand latch, round counter, pending mask, accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      round   <= '0;
      pending <= '0;
      acc     <= '0;
      args_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            args_q <= args;
            acc    <= '0;
            round  <= '0;
          end
        end
        ST_ISSUE: pending <= issue_mask;
        ST_WAIT: begin
          acc     <= acc + arrive_sum;
          pending <= pending_left;
          if (all_clear && !last_round) begin
            round <= round + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_formula_sum_isqrt_n_fsm.sv
module tb_formula_sum_isqrt_n_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks   = 0;
  int   failures = 0;

  // Three configurations: A = 3 args/2 units, B = 5 args/2 units, C = 3 args/4 units.
  localparam int NA [3] = '{3, 5, 3};
  localparam int NU [3] = '{2, 2, 4};

  logic         vld_in  [3];
  logic [255:0] args_in [3];
  logic [3:0]   yv_bits [3];
  logic [63:0]  yd_bits [3];
  logic [3:0]   xv_bits [3];
  logic [127:0] xd_bits [3];
  logic         rdy_o   [3];
  logic         rv_o    [3];
  logic [31:0]  res_o   [3];

  int           cnt       [3][4];
  logic [15:0]  val       [3][4];
  int           lat_cfg   [3][4];
  int           issue_cnt [3];
  int           x_dirty = 0;
  bit           spur_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] isqrt_f(input logic [31:0] v);
    longint r = 0;
    longint t;
    for (int b = 15; b >= 0; b--) begin
      t = r + (longint'(1) << b);
      if (t * t <= longint'(v)) r = t;
    end
    return r[15:0];
  endfunction

  // DUT A
  logic a_rdy, a_rv; logic [31:0] a_res; logic [1:0] a_xv; logic [63:0] a_x;
  formula_sum_isqrt_n_fsm #(.W(32), .N_ARGS(3), .N_UNITS(2)) dut_a (
    .clk(clk), .rst(rst), .arg_vld(vld_in[0]), .arg_rdy(a_rdy), .args(args_in[0][95:0]),
    .res_vld(a_rv), .res(a_res), .isqrt_x_vld(a_xv), .isqrt_x(a_x),
    .isqrt_y_vld(yv_bits[0][1:0]), .isqrt_y(yd_bits[0][31:0]));
  assign xv_bits[0] = {2'b0, a_xv};
  assign xd_bits[0] = {64'b0, a_x};
  assign rdy_o[0] = a_rdy; assign rv_o[0] = a_rv; assign res_o[0] = a_res;

  // DUT B
  logic b_rdy, b_rv; logic [31:0] b_res; logic [1:0] b_xv; logic [63:0] b_x;
  formula_sum_isqrt_n_fsm #(.W(32), .N_ARGS(5), .N_UNITS(2)) dut_b (
    .clk(clk), .rst(rst), .arg_vld(vld_in[1]), .arg_rdy(b_rdy), .args(args_in[1][159:0]),
    .res_vld(b_rv), .res(b_res), .isqrt_x_vld(b_xv), .isqrt_x(b_x),
    .isqrt_y_vld(yv_bits[1][1:0]), .isqrt_y(yd_bits[1][31:0]));
  assign xv_bits[1] = {2'b0, b_xv};
  assign xd_bits[1] = {64'b0, b_x};
  assign rdy_o[1] = b_rdy; assign rv_o[1] = b_rv; assign res_o[1] = b_res;

  // DUT C
  logic c_rdy, c_rv; logic [31:0] c_res; logic [3:0] c_xv; logic [127:0] c_x;
  formula_sum_isqrt_n_fsm #(.W(32), .N_ARGS(3), .N_UNITS(4)) dut_c (
    .clk(clk), .rst(rst), .arg_vld(vld_in[2]), .arg_rdy(c_rdy), .args(args_in[2][95:0]),
    .res_vld(c_rv), .res(c_res), .isqrt_x_vld(c_xv), .isqrt_x(c_x),
    .isqrt_y_vld(yv_bits[2]), .isqrt_y(yd_bits[2]));
  assign xv_bits[2] = c_xv;
  assign xd_bits[2] = c_x;
  assign rdy_o[2] = c_rdy; assign rv_o[2] = c_rv; assign res_o[2] = c_res;

  // Behavioural isqrt units: result L cycles after the request (L from lat_cfg,
  // 0 meaning random 1..5); idle units optionally emit junk y_vld pulses.
  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      for (int u = 0; u < 4; u++) begin
        yv_bits[c][u] = 1'b0;
        yd_bits[c][u*16 +: 16] = 16'h0;
        if (u < NU[c]) begin
          if (rst) begin
            cnt[c][u] = 0;
          end else begin
            if (!xv_bits[c][u] && xd_bits[c][u*32 +: 32] != 32'h0) x_dirty++;
            if (cnt[c][u] > 0) begin
              cnt[c][u]--;
              if (cnt[c][u] == 0) begin
                yv_bits[c][u] = 1'b1;
                yd_bits[c][u*16 +: 16] = val[c][u];
              end
            end
            if (xv_bits[c][u]) begin
              issue_cnt[c]++;
              val[c][u] = isqrt_f(xd_bits[c][u*32 +: 32]);
              cnt[c][u] = (lat_cfg[c][u] > 0) ? lat_cfg[c][u] : int'($urandom_range(1, 5));
            end
            if (spur_en && cnt[c][u] == 0 && !yv_bits[c][u] && !xv_bits[c][u] &&
                $urandom_range(0, 1) == 1) begin
              yv_bits[c][u] = 1'b1;
              yd_bits[c][u*16 +: 16] = 16'($urandom);
            end
          end
        end
      end
    end
  end

  // One operation on DUT c; called and returning at a negedge.
  // lat > 0 enables the exact-latency check with round time lat+1.
  task automatic do_op(input int c, input logic [31:0] a [8], input logic [31:0] nxt [8],
                       input bit hold, input int lat, input string tag);
    logic [31:0] exp_res = 32'h0;
    logic [31:0] got_res = 32'h0;
    int rounds, done_cyc, wait_n;
    bit busy_ok = 1'b1;
    for (int i = 0; i < NA[c]; i++) exp_res = exp_res + {16'h0, isqrt_f(a[i])};
    rounds = (NA[c] + NU[c] - 1) / NU[c];
    for (int i = 0; i < 8; i++) args_in[c][i*32 +: 32] = a[i];
    vld_in[c] = 1'b1;
    wait_n = 0;
    while (!rdy_o[c] && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    if (!rdy_o[c]) begin
      check({tag, "_accept"}, 64'(rdy_o[c]), 64'd1);
      vld_in[c] = 1'b0;
      return;
    end
    issue_cnt[c] = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) args_in[c][i*32 +: 32] = nxt[i];
    vld_in[c] = hold;
    done_cyc = -1;
    for (int cyc = 1; cyc < 200 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (rdy_o[c]) busy_ok = 1'b0;
      if (rv_o[c]) begin
        done_cyc = cyc;
        got_res  = res_o[c];
      end
    end
    check({tag, "_done_seen"}, 64'(done_cyc > 0), 64'd1);
    if (done_cyc > 0) begin
      check({tag, "_res"}, 64'(got_res), 64'(exp_res));
      if (lat > 0) check({tag, "_latency"}, 64'(done_cyc), 64'(rounds * (lat + 1) + 1));
      check({tag, "_rdy_low_busy"}, 64'(busy_ok), 64'd1);
      check({tag, "_requests"}, 64'(issue_cnt[c]), 64'(NA[c]));
      @(negedge clk);
      check({tag, "_after_done"}, {30'h0, rv_o[c], rdy_o[c], res_o[c]}, {30'h0, 1'b0, 1'b1, exp_res});
    end
  endtask

  logic [31:0] av [8];
  logic [31:0] nv [8];
  bit          rv_seen;

  initial begin
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      vld_in[c] = 1'b0;
      args_in[c] = '0;
      issue_cnt[c] = 0;
      for (int u = 0; u < 4; u++) lat_cfg[c][u] = 3;
    end
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3; c++) check($sformatf("reset_res_%0d", c), {31'h0, rv_o[c], res_o[c]}, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) check($sformatf("reset_rdy_%0d", c), {59'h0, rdy_o[c], xv_bits[c]}, {59'h0, 1'b1, 4'h0});

    // Basic: defaults, L=3, 18 in cycle 9.
    av = '{16, 25, 81, 0, 0, 0, 0, 0};
    nv = '{0, 0, 0, 0, 0, 0, 0, 0};
    do_op(0, av, nv, 1'b0, 3, "t1_a");

    // Five args over two units, partial last round, max operand.
    av = '{0, 1, 4, 9, 32'hFFFFFFFF, 0, 0, 0};
    do_op(1, av, nv, 1'b0, 3, "t2_b");

    // Out of order: unit 1 returns two cycles before unit 0; then equal latency; junk pulses.
    spur_en = 1'b1;
    lat_cfg[1][0] = 4; lat_cfg[1][1] = 2;
    av = '{100, 2000, 30000, 400000, 5000000, 0, 0, 0};
    do_op(1, av, nv, 1'b0, 4, "t3_b_ooo");
    lat_cfg[1][0] = 3; lat_cfg[1][1] = 3;
    av = '{7, 77, 777, 7777, 77777, 0, 0, 0};
    do_op(1, av, nv, 1'b0, 3, "t3_b_same");
    lat_cfg[0][0] = 4; lat_cfg[0][1] = 2;
    av = '{144, 169, 196, 0, 0, 0, 0, 0};
    do_op(0, av, nv, 1'b0, 4, "t3_a_ooo");
    lat_cfg[0][0] = 3; lat_cfg[0][1] = 3;

    // Back-to-back with arg_vld held; args changed while busy must not matter.
    av = '{1, 4, 9, 0, 0, 0, 0, 0};
    nv = '{100, 100, 100, 0, 0, 0, 0, 0};
    do_op(0, av, nv, 1'b1, 3, "t4_first");
    av = '{100, 100, 100, 0, 0, 0, 0, 0};
    nv = '{7, 7, 7, 0, 0, 0, 0, 0};
    do_op(0, av, nv, 1'b0, 3, "t4_second");

    // Reset during WAIT of round 0.
    rv_seen = 1'b0;
    args_in[0][95:0] = {32'd9, 32'd9, 32'd9};
    vld_in[0] = 1'b1;
    @(posedge clk);
    #1;
    vld_in[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("t5_rdy_after_reset", 64'(rdy_o[0]), 64'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rv_o[0]) rv_seen = 1'b1;
    end
    check("t5_no_res_vld", 64'(rv_seen), 64'd0);
    av = '{4, 4, 4, 0, 0, 0, 0, 0};
    nv = '{0, 0, 0, 0, 0, 0, 0, 0};
    do_op(0, av, nv, 1'b0, 3, "t5_after");

    // More units than args: single round.
    av = '{1, 1, 1, 0, 0, 0, 0, 0};
    do_op(2, av, nv, 1'b0, 3, "t6_c");

    // Randomized operands and per-request latencies on all configurations.
    for (int c = 0; c < 3; c++) for (int u = 0; u < 4; u++) lat_cfg[c][u] = 0;
    for (int it = 0; it < 12; it++) begin
      for (int c = 0; c < 3; c++) begin
        for (int i = 0; i < 8; i++) begin
          av[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom);
          nv[i] = 32'($urandom);
        end
        do_op(c, av, nv, 1'b0, 0, $sformatf("rnd_%0d_%0d", c, it));
      end
    end

    check("x_zero_when_idle", 64'(x_dirty), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
